// File: rtl/hs4_push_sender_pkg.sv
// Shared definitions for the four-phase push channel.
// State encodings are fixed so the matching receiver and benches agree.
package hs4_push_sender_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        ACK_HI = 2'd3
    } state_t;

    localparam int TMO_W = 8;

endpackage

// File: rtl/hs4_fifo.sv
// Input word buffer for the four-phase sender.
// Circular buffer; every update is qualified by ENA.
module hs4_fifo
    import hs4_push_sender_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CK,
    input  logic                     RS,
    input  logic                     ENA,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign ready   = (cnt != CW'(DEPTH));
    assign do_push = ENA & push & ready;
    assign do_pop  = ENA & pop & (cnt != '0);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; COUNT gates every read.
    always_ff @(posedge CK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hs4_push_sender.sv
// Active end of a four-phase RTZ bundled-data channel.
// Buffers upstream words and drives REQ/DATA, stepping only on ENA.
module hs4_push_sender
    import hs4_push_sender_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     CK,
    input  logic                     RS,
    input  logic                     ENA,
    input  logic                     IN_VALID,
    input  logic [WIDTH-1:0]         IN_DATA,
    output logic                     IN_READY,
    output logic                     REQ,
    output logic [WIDTH-1:0]         DATA,
    input  logic                     ACK,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     BUSY,
    output logic                     ERR,
    input  logic                     ERR_CLR
);

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] tmo_inc;
    logic             err_q, err_d;
    logic             waiting;
    logic             pop;
    logic [WIDTH-1:0] head;

    hs4_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CK    (CK),
        .RS    (RS),
        .ENA   (ENA),
        .push  (IN_VALID),
        .wdata (IN_DATA),
        .pop   (pop),
        .head  (head),
        .count (COUNT),
        .ready (IN_READY)
    );

    assign tmo_inc = tmo_q + 1'b1;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        err_d   = err_q & ~ERR_CLR;
        waiting = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ACK still high means the receiver has not finished RTZ.
                if (COUNT != '0 && !ACK) begin
                    state_d = SETUP;
                    data_d  = head;
                end
            end
            SETUP: begin
                state_d = REQ_HI;
                req_d   = 1'b1;
                tmo_d   = '0;
            end
            REQ_HI: begin
                if (ACK) begin
                    state_d = ACK_HI;
                    req_d   = 1'b0;
                    pop     = 1'b1;
                    tmo_d   = '0;
                end else begin
                    waiting = 1'b1;
                end
            end
            ACK_HI: begin
                if (!ACK) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    waiting = 1'b1;
                end
            end
        endcase
        // Counter parks at the limit so ERR is raised once per stall.
        if (waiting && tmo_q != TMO_MAX) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO_MAX) err_d = 1'b1;
        end
    end

    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else if (ENA) begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign REQ  = req_q;
    assign DATA = data_q;
    assign ERR  = err_q;
    assign BUSY = (state_q != IDLE) || (COUNT != '0);

endmodule
